// File: rtl/bd_tag_pkg.sv
// Shared constants and word layouts for the BD tag/count merge and split paths.
// Used by bd_tag_split (optional counters: BD_TAG_SPLIT_COUNT_EN).
package bd_tag_pkg;

    localparam int NBDData = 20;
    localparam int Ncode   = 6;
    localparam int Ntag    = 11;
    localparam int Nct     = 9;

    localparam int TAG_CT_CODE = 30;

    typedef struct packed {
        logic [NBDData-1:0] payload;
        logic [Ncode-1:0]   leaf_code;
    } bd_word_t;

    typedef struct packed {
        logic [Ntag-1:0] tag;
        logic [Nct-1:0]  ct;
    } tag_ct_t;

endpackage

// File: rtl/bd_tag_split_skid.sv
// 2-entry valid/accept skid buffer; entry 0 drives the output directly,
// so there is no combinational path from input to output.
module skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_v,
    input  logic [W-1:0] in_d,
    output logic         in_a,
    output logic         out_v,
    output logic [W-1:0] out_d,
    input  logic         out_a
);

    logic [1:0]   r_cnt;
    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic         w_push;
    logic         w_pop;

    assign in_a   = (r_cnt != 2'd2);
    assign out_v  = (r_cnt != 2'd0);
    assign out_d  = r_d0;
    assign w_push = in_v & in_a;
    assign w_pop  = out_v & out_a;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 2'd0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_d0  <= in_d;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    // push+pop replaces the head in place: no bubble
                    if (w_push && w_pop) begin
                        r_d0 <= in_d;
                    end else if (w_push) begin
                        r_d1  <= in_d;
                        r_cnt <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_d0  <= r_d1;
                        r_cnt <= 2'd1;
                    end
                end
                default: r_cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/bd_tag_split.sv
// Splits the BD word stream into tag/count words (leaf_code == TAG_CT_CODE) and BD words.
// Define BD_TAG_SPLIT_COUNT_EN to add saturating transfer counters n_tag_ct / n_bd.
module bd_tag_split #(
    parameter int NBDData = bd_tag_pkg::NBDData,
    parameter int Ncode   = bd_tag_pkg::Ncode,
    parameter int Ntag    = bd_tag_pkg::Ntag,
    parameter int Nct     = bd_tag_pkg::Nct
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_v,
    input  logic [NBDData-1:0] in_payload,
    input  logic [Ncode-1:0]   in_leaf_code,
    output logic               in_a,
    output logic               bd_out_v,
    output logic [NBDData-1:0] bd_out_payload,
    output logic [Ncode-1:0]   bd_out_leaf_code,
    input  logic               bd_out_a,
    output logic               tag_ct_out_v,
    output logic [Ntag-1:0]    tag_ct_out_tag,
    output logic [Nct-1:0]     tag_ct_out_ct,
    input  logic               tag_ct_out_a
`ifdef BD_TAG_SPLIT_COUNT_EN
    ,
    output logic [15:0]        n_tag_ct,
    output logic [15:0]        n_bd
`endif
);

    import bd_tag_pkg::*;

    localparam int WBd = NBDData + Ncode;
    localparam int WTc = Ntag + Nct;

    if (NBDData != Ntag + Nct) begin : g_width_chk
        $error("bd_tag_split: NBDData must equal Ntag+Nct");
    end

    logic           w_is_tag;
    logic           w_bd_in_a;
    logic           w_tc_in_a;
    logic           w_bd_in_v;
    logic           w_tc_in_v;
    logic [WBd-1:0] w_bd_out_d;
    logic [WTc-1:0] w_tc_out_d;

    assign w_is_tag  = (in_leaf_code == Ncode'(TAG_CT_CODE));
    // head-of-line: only the buffer this word targets gates acceptance
    assign in_a      = reset_n & (w_is_tag ? w_tc_in_a : w_bd_in_a);
    assign w_bd_in_v = in_v & ~w_is_tag;
    assign w_tc_in_v = in_v & w_is_tag;

    skid_buf2 #(.W(WBd)) u_bd_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .in_v    (w_bd_in_v),
        .in_d    ({in_payload, in_leaf_code}),
        .in_a    (w_bd_in_a),
        .out_v   (bd_out_v),
        .out_d   (w_bd_out_d),
        .out_a   (bd_out_a)
    );

    skid_buf2 #(.W(WTc)) u_tc_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .in_v    (w_tc_in_v),
        .in_d    ({in_payload[NBDData-1 -: Ntag], in_payload[Nct-1:0]}),
        .in_a    (w_tc_in_a),
        .out_v   (tag_ct_out_v),
        .out_d   (w_tc_out_d),
        .out_a   (tag_ct_out_a)
    );

    assign {bd_out_payload, bd_out_leaf_code} = w_bd_out_d;
    assign {tag_ct_out_tag, tag_ct_out_ct}    = w_tc_out_d;

`ifdef BD_TAG_SPLIT_COUNT_EN
    logic [15:0] r_n_tag_ct;
    logic [15:0] r_n_bd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n_tag_ct <= 16'd0;
            r_n_bd     <= 16'd0;
        end else begin
            if (tag_ct_out_v && tag_ct_out_a && r_n_tag_ct != 16'hFFFF)
                r_n_tag_ct <= r_n_tag_ct + 16'd1;
            if (bd_out_v && bd_out_a && r_n_bd != 16'hFFFF)
                r_n_bd <= r_n_bd + 16'd1;
        end
    end

    assign n_tag_ct = r_n_tag_ct;
    assign n_bd     = r_n_bd;
`endif

endmodule

// File: tb/tb_bd_tag_split.sv
// Randomized + directed bench for bd_tag_split with a queue-based reference model.
// Counter checks run only when BD_TAG_SPLIT_COUNT_EN is defined.
module tb_bd_tag_split;

    import bd_tag_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_v;
    logic [19:0] in_payload;
    logic [5:0]  in_leaf_code;
    logic        in_a;
    logic        bd_out_v;
    logic [19:0] bd_out_payload;
    logic [5:0]  bd_out_leaf_code;
    logic        bd_out_a;
    logic        tag_ct_out_v;
    logic [10:0] tag_ct_out_tag;
    logic [8:0]  tag_ct_out_ct;
    logic        tag_ct_out_a;
`ifdef BD_TAG_SPLIT_COUNT_EN
    logic [15:0] n_tag_ct;
    logic [15:0] n_bd;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;
    bit rnd_en  = 0;

    bd_word_t bd_q[$];
    tag_ct_t  tc_q[$];
    int       bd_pops = 0;
    int       tc_pops = 0;
    int       m_cnt_bd = 0;
    int       m_cnt_tc = 0;

    always #5 clk = ~clk;

    bd_tag_split dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_v             (in_v),
        .in_payload       (in_payload),
        .in_leaf_code     (in_leaf_code),
        .in_a             (in_a),
        .bd_out_v         (bd_out_v),
        .bd_out_payload   (bd_out_payload),
        .bd_out_leaf_code (bd_out_leaf_code),
        .bd_out_a         (bd_out_a),
        .tag_ct_out_v     (tag_ct_out_v),
        .tag_ct_out_tag   (tag_ct_out_tag),
        .tag_ct_out_ct    (tag_ct_out_ct),
        .tag_ct_out_a     (tag_ct_out_a)
`ifdef BD_TAG_SPLIT_COUNT_EN
        ,
        .n_tag_ct         (n_tag_ct),
        .n_bd             (n_bd)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: a word sits in its output's queue from input transfer until output transfer.
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            bd_word_t w;
            tag_ct_t  t;
            bit       exp_a;
            chk("bd_v", 32'(bd_out_v), 32'(bd_q.size() != 0));
            if (bd_q.size() != 0)
                chk("bd_d", 32'({bd_out_payload, bd_out_leaf_code}), 32'(bd_q[0]));
            chk("tc_v", 32'(tag_ct_out_v), 32'(tc_q.size() != 0));
            if (tc_q.size() != 0)
                chk("tc_d", 32'({tag_ct_out_tag, tag_ct_out_ct}), 32'(tc_q[0]));
            exp_a = (in_leaf_code == 6'd30) ? (tc_q.size() < 2) : (bd_q.size() < 2);
            chk("in_a", 32'(in_a), 32'(exp_a));
`ifdef BD_TAG_SPLIT_COUNT_EN
            chk("n_bd", 32'(n_bd), 32'(m_cnt_bd > 65535 ? 65535 : m_cnt_bd));
            chk("n_tag_ct", 32'(n_tag_ct), 32'(m_cnt_tc > 65535 ? 65535 : m_cnt_tc));
`endif
            if (bd_out_v && bd_out_a && bd_q.size() != 0) begin
                void'(bd_q.pop_front());
                bd_pops++;
                m_cnt_bd++;
            end
            if (tag_ct_out_v && tag_ct_out_a && tc_q.size() != 0) begin
                void'(tc_q.pop_front());
                tc_pops++;
                m_cnt_tc++;
            end
            if (in_v && in_a) begin
                if (in_leaf_code == 6'd30) begin
                    t.tag = 11'(in_payload / 512);
                    t.ct  = 9'(in_payload % 512);
                    tc_q.push_back(t);
                end else begin
                    w.payload   = in_payload;
                    w.leaf_code = in_leaf_code;
                    bd_q.push_back(w);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) begin
                bd_out_a     = 1'($urandom_range(0, 1));
                tag_ct_out_a = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic [5:0] c, input logic [19:0] p);
        bit ok;
        int k;
        ok = 0;
        k  = 0;
        in_v         = 1'b1;
        in_leaf_code = c;
        in_payload   = p;
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = in_a;
            @(posedge clk);
            #1;
            k++;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout observed=stalled expected=accepted");
        end
        in_v = 1'b0;
    endtask

    initial begin
        int start;
        int k;
        reset_n      = 1'b0;
        in_v         = 1'b0;
        in_payload   = '0;
        in_leaf_code = 6'd5;
        bd_out_a     = 1'b0;
        tag_ct_out_a = 1'b0;

        // 1: reset then idle
        #13;
        chk("rst_in_a", 32'(in_a), 32'd0);
        chk("rst_bd_v", 32'(bd_out_v), 32'd0);
        chk("rst_tc_v", 32'(tag_ct_out_v), 32'd0);
        chk("rst_bd_d", 32'({bd_out_payload, bd_out_leaf_code}), 32'd0);
        chk("rst_tc_d", 32'({tag_ct_out_tag, tag_ct_out_ct}), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        mon_en = 1;
        @(negedge clk);
        chk("idle_in_a", 32'(in_a), 32'd1);
`ifdef BD_TAG_SPLIT_COUNT_EN
        chk("idle_cnt", 32'({n_tag_ct, n_bd}), 32'd0);
`endif
        @(posedge clk);
        #1;

        // 2: single tag word
        tag_ct_out_a = 1'b1;
        send(6'd30, 20'hABCDE);
        chk("t2_tc_v", 32'(tag_ct_out_v), 32'd1);
        chk("t2_tag", 32'(tag_ct_out_tag), 32'h55E);
        chk("t2_ct", 32'(tag_ct_out_ct), 32'h0DE);
        chk("t2_bd_v", 32'(bd_out_v), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // 3: back-to-back BD stream
        bd_out_a = 1'b1;
        start = bd_pops;
        for (int i = 1; i <= 8; i++) send(6'd5, 20'(i));
        repeat (3) @(posedge clk);
        #1;
        chk("t3_count", 32'(bd_pops - start), 32'd8);

        // 4: head-of-line stall
        bd_out_a = 1'b0;
        send(6'd3, 20'd100);
        send(6'd3, 20'd101);
        in_v         = 1'b1;
        in_leaf_code = 6'd3;
        in_payload   = 20'd102;
        repeat (3) begin
            @(negedge clk);
            chk("t4_hol_in_a", 32'(in_a), 32'd0);
        end
        @(posedge clk);
        #1 bd_out_a = 1'b1;
        send(6'd3, 20'd102);
        send(6'd30, 20'd200);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_bd_empty", 32'(bd_q.size()), 32'd0);
        chk("t4_tc_empty", 32'(tc_q.size()), 32'd0);

        // 5: alternating routes with random back-pressure
        rnd_en = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0)
                send((i % 2 == 0) ? 6'd30 : 6'd7, 20'($urandom));
            else begin
                @(posedge clk);
                #1;
            end
        end
        rnd_en = 0;
        @(posedge clk);
        #1;
        bd_out_a     = 1'b1;
        tag_ct_out_a = 1'b1;
        k = 0;
        while ((bd_q.size() != 0 || tc_q.size() != 0) && k < 20) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("t5_drain", 32'(bd_q.size() + tc_q.size()), 32'd0);

        // 6: reset with both buffers full
        bd_out_a     = 1'b0;
        tag_ct_out_a = 1'b0;
        send(6'd30, 20'h12345);
        send(6'd30, 20'h6789A);
        send(6'd9, 20'hBCDEF);
        send(6'd9, 20'h13579);
        @(negedge clk);
        chk("t6_full_bd_v", 32'(bd_out_v), 32'd1);
        chk("t6_full_tc_v", 32'(tag_ct_out_v), 32'd1);
        chk("t6_full_in_a", 32'(in_a), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_bd_v", 32'(bd_out_v), 32'd0);
        chk("t6_rst_tc_v", 32'(tag_ct_out_v), 32'd0);
        chk("t6_rst_in_a", 32'(in_a), 32'd0);
        chk("t6_rst_bd_d", 32'({bd_out_payload, bd_out_leaf_code}), 32'd0);
        bd_q.delete();
        tc_q.delete();
        m_cnt_bd = 0;
        m_cnt_tc = 0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        bd_out_a     = 1'b1;
        tag_ct_out_a = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_stale_bd", 32'(bd_out_v), 32'd0);
            chk("t6_stale_tc", 32'(tag_ct_out_v), 32'd0);
        end
`ifdef BD_TAG_SPLIT_COUNT_EN
        chk("t6_cnt_clr", 32'({n_tag_ct, n_bd}), 32'd0);
        @(posedge clk);
        #1;
        in_leaf_code = 6'd5;
        in_payload   = 20'h00042;
        in_v         = 1'b1;
        repeat (65545) @(posedge clk);
        #1 in_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_sat_n_bd", 32'(n_bd), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
